// File: rtl/pulse_to_level_pkg.sv
// Shared definitions for the pulse_to_level slice.
//   state_t       : FSM encoding (IDLE=00, HOLD=01, GAP=10; 11 is unused)
//   is_active     : helper, true for any state that drives busy
package pulse_to_level_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    function automatic logic is_active(input state_t s);
        return (s == ST_HOLD) || (s == ST_GAP);
    endfunction

endpackage

// File: rtl/pulse_to_level_sat_counter.sv
// Saturating up/down counter used as the pending-pulse queue.
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  synchronous active-low reset
//   inc      in   1  add one (held at all-ones when saturated)
//   dec      in   1  subtract one (held at zero when empty)
//   clr      in   1  synchronous clear to zero
//   count    out  W  current count (registered)
//   sat_hit  out  1  combinational: an increment is being lost this cycle
module sat_updown_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat_hit
);

    logic at_max;
    logic at_min;

    always_comb begin
        at_max  = (count == '1);
        at_min  = (count == '0);
        // Simultaneous inc and dec cancel, so only a lone inc can be lost.
        sat_hit = inc && !dec && at_max;
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            count <= '0;
        end else if (inc && !dec && !at_max) begin
            count <= count + 1'b1;
        end else if (dec && !inc && !at_min) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/pulse_to_level.sv
// Pulse stretcher: each accepted single-cycle pulse produces one window of
// HOLD_CYCLES high on level_out followed by GAP_CYCLES forced low. Pulses
// arriving while busy are queued (or reload the window when RETRIGGER=1).
// Ports:
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous active-low reset
//   pulse_in   in   1       request; each high cycle counts as one pulse
//   clear      in   1       synchronous abort: drops level, flushes queue/overflow
//   level_out  out  1       stretched level (registered)
//   busy       out  1       high while not IDLE (registered)
//   pending    out  PEND_W  queued pulses not yet serviced
//   overflow   out  1       sticky: a pulse was lost at queue saturation
module pulse_to_level
    import pulse_to_level_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES  = 25_000_000,
    parameter int unsigned CNT_W       = 26,
    parameter int unsigned PEND_W      = 4,
    parameter bit          RETRIGGER   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    input  logic              clear,
    output logic              level_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic             timer_zero;
    logic             queue_inc;
    logic             queue_dec;
    logic             sat_hit;
    logic             queue_nonempty;

    always_comb begin
        timer_zero     = (timer == '0);
        queue_nonempty = (pending != '0) || pulse_in;
        queue_inc      = 1'b0;
        queue_dec      = 1'b0;
        if (!clear) begin
            if (pulse_in && ((state == ST_HOLD && !RETRIGGER) || state == ST_GAP)) begin
                queue_inc = 1'b1;
            end
            // Leaving GAP into a new window consumes one queued pulse; a
            // same-cycle pulse_in counts toward the queue and cancels inside
            // the counter.
            if (state == ST_GAP && timer_zero && queue_nonempty) begin
                queue_dec = 1'b1;
            end
        end
    end

    sat_updown_counter #(
        .W (PEND_W)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .inc     (queue_inc),
        .dec     (queue_dec),
        .clr     (clear),
        .count   (pending),
        .sat_hit (sat_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            overflow <= 1'b0;
        end else if (sat_hit) begin
            overflow <= 1'b1;
        end
    end

    // FSM with outputs registered alongside the next state.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            state     <= ST_IDLE;
            timer     <= '0;
            level_out <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pulse_in) begin
                        state     <= ST_HOLD;
                        timer     <= HOLD_LOAD;
                        level_out <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // A retrigger on the final HOLD cycle still wins over the exit.
                    if (RETRIGGER && pulse_in) begin
                        timer <= HOLD_LOAD;
                    end else if (timer_zero) begin
                        state     <= ST_GAP;
                        timer     <= GAP_LOAD;
                        level_out <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (timer_zero) begin
                        if (queue_nonempty) begin
                            state     <= ST_HOLD;
                            timer     <= HOLD_LOAD;
                            level_out <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    timer     <= '0;
                    level_out <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_to_level.sv
// Directed bench for pulse_to_level with HOLD=4, GAP=2, PEND_W=2.
// Cycle c is the interval after the c-th clock edge of a scenario; inputs
// driven in cycle c are sampled at the edge that starts cycle c+1.
module tb_pulse_to_level;

    logic       clk = 1'b0;
    logic       rst;
    logic       pulse_in;
    logic       clear;
    logic       level0, busy0, ovf0;
    logic       level1, busy1, ovf1;
    logic [1:0] pend0, pend1;

    int unsigned checks = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    pulse_to_level #(
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (2),
        .CNT_W       (2),
        .PEND_W      (2),
        .RETRIGGER   (1'b0)
    ) dut0 (
        .clk       (clk),
        .rst       (rst),
        .pulse_in  (pulse_in),
        .clear     (clear),
        .level_out (level0),
        .busy      (busy0),
        .pending   (pend0),
        .overflow  (ovf0)
    );

    pulse_to_level #(
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (2),
        .CNT_W       (2),
        .PEND_W      (2),
        .RETRIGGER   (1'b1)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .pulse_in  (pulse_in),
        .clear     (clear),
        .level_out (level1),
        .busy      (busy1),
        .pending   (pend1),
        .overflow  (ovf1)
    );

    // Reset for one edge, then leave the bench at cycle 0 of a new scenario.
    task automatic fresh_start();
        rst      = 1'b0;
        pulse_in = 1'b0;
        clear    = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [4:0] got0, got1;
        rst      = 1'b0;
        pulse_in = 1'b1;
        clear    = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c <= 10; c++) begin
            rst      = (c >= 3);
            pulse_in = (c <= 2);
            got0 = {level0, busy0, pend0, ovf0};
            got1 = {level1, busy1, pend1, ovf1};
            checks++;
            if (got0 !== 5'b0) $display("FAIL reset_r0 cyc=%0d got=%b exp=%b", c, got0, 5'b0);
            else passed++;
            checks++;
            if (got1 !== 5'b0) $display("FAIL reset_r1 cyc=%0d got=%b exp=%b", c, got1, 5'b0);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single();
        logic [4:0] exp, got0, got1;
        fresh_start();
        for (int c = 0; c <= 20; c++) begin
            pulse_in = (c == 10);
            exp  = {(c >= 11 && c <= 14), (c >= 11 && c <= 16), 2'd0, 1'b0};
            got0 = {level0, busy0, pend0, ovf0};
            got1 = {level1, busy1, pend1, ovf1};
            checks++;
            if (got0 !== exp) $display("FAIL single_r0 cyc=%0d got=%b exp=%b", c, got0, exp);
            else passed++;
            checks++;
            if (got1 !== exp) $display("FAIL single_r1 cyc=%0d got=%b exp=%b", c, got1, exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_queue();
        logic [4:0] exp, got;
        logic [1:0] ep;
        fresh_start();
        for (int c = 0; c <= 32; c++) begin
            pulse_in = (c == 10 || c == 12 || c == 13);
            if (c == 13)                 ep = 2'd1;
            else if (c >= 14 && c <= 16) ep = 2'd2;
            else if (c >= 17 && c <= 22) ep = 2'd1;
            else                         ep = 2'd0;
            exp = {((c >= 11 && c <= 14) || (c >= 17 && c <= 20) || (c >= 23 && c <= 26)),
                   (c >= 11 && c <= 28), ep, 1'b0};
            got = {level0, busy0, pend0, ovf0};
            checks++;
            if (got !== exp) $display("FAIL queue cyc=%0d got=%b exp=%b", c, got, exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_retrigger();
        logic [4:0] exp, got;
        fresh_start();
        for (int c = 0; c <= 24; c++) begin
            pulse_in = (c == 10 || c == 13);
            exp = {(c >= 11 && c <= 17), (c >= 11 && c <= 19), 2'd0, 1'b0};
            got = {level1, busy1, pend1, ovf1};
            checks++;
            if (got !== exp) $display("FAIL retrigger cyc=%0d got=%b exp=%b", c, got, exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    // Pulse on the last HOLD cycle: reload beats the exit to GAP.
    task automatic test_retrigger_edge();
        logic [4:0] exp, got;
        fresh_start();
        for (int c = 0; c <= 24; c++) begin
            pulse_in = (c == 10 || c == 14);
            exp = {(c >= 11 && c <= 18), (c >= 11 && c <= 20), 2'd0, 1'b0};
            got = {level1, busy1, pend1, ovf1};
            checks++;
            if (got !== exp) $display("FAIL retrig_edge cyc=%0d got=%b exp=%b", c, got, exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        logic [4:0] exp, got;
        logic [1:0] ep;
        fresh_start();
        for (int c = 0; c <= 40; c++) begin
            pulse_in = (c >= 10 && c <= 15);
            if (c == 12)                 ep = 2'd1;
            else if (c == 13)            ep = 2'd2;
            else if (c >= 14 && c <= 16) ep = 2'd3;
            else if (c >= 17 && c <= 22) ep = 2'd2;
            else if (c >= 23 && c <= 28) ep = 2'd1;
            else                         ep = 2'd0;
            exp = {((c >= 11 && c <= 14) || (c >= 17 && c <= 20) ||
                    (c >= 23 && c <= 26) || (c >= 29 && c <= 32)),
                   (c >= 11 && c <= 34), ep, (c >= 15)};
            got = {level0, busy0, pend0, ovf0};
            checks++;
            if (got !== exp) $display("FAIL saturation cyc=%0d got=%b exp=%b", c, got, exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    // clear with no preceding reset also flushes the sticky overflow left
    // by the saturation scenario.
    task automatic test_clear();
        logic [4:0] exp, got;
        rst      = 1'b1;
        pulse_in = 1'b0;
        clear    = 1'b0;
        for (int c = 0; c <= 24; c++) begin
            pulse_in = (c == 10 || c == 12 || c == 14);
            clear    = (c == 12);
            exp = {((c >= 11 && c <= 12) || (c >= 15 && c <= 18)),
                   ((c >= 11 && c <= 12) || (c >= 15 && c <= 20)),
                   2'd0, (c <= 12)};
            got = {level0, busy0, pend0, ovf0};
            checks++;
            if (got !== exp) $display("FAIL clear cyc=%0d got=%b exp=%b", c, got, exp);
            else passed++;
            @(posedge clk); #1;
        end
        clear = 1'b0;
    endtask

    // Saturated queue plus a pulse on the GAP exit cycle: inc and dec cancel,
    // pending holds at 3 and no new overflow is recorded.
    task automatic test_back_to_back();
        logic [4:0] exp, got;
        logic [1:0] ep;
        fresh_start();
        for (int c = 0; c <= 20; c++) begin
            pulse_in = (c >= 10 && c <= 13) || (c == 16);
            if (c == 12)      ep = 2'd1;
            else if (c == 13) ep = 2'd2;
            else if (c >= 14) ep = 2'd3;
            else              ep = 2'd0;
            exp = {((c >= 11 && c <= 14) || (c >= 17 && c <= 20)),
                   (c >= 11), ep, 1'b0};
            got = {level0, busy0, pend0, ovf0};
            checks++;
            if (got !== exp) $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, got, exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_queue();
        test_retrigger();
        test_retrigger_edge();
        test_saturation();
        test_clear();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
